// File: rtl/fetch_pc_pkg.sv
// Shared processor definitions for the fetch stage: PC select encodings,
// fetch FSM states and the default reset/trap vectors.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ     = 2'b00,
    PC_JALR    = 2'b01,
    PC_BRANCH  = 2'b10,
    PC_SEQ_ALT = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational redirect decode: picks the control-transfer target and
// flags targets that are not word aligned.
module next_pc_sel
  import fetch_pc_pkg::*;
(
  input  logic [1:0]  i_pc_selection,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_alu_result,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic        o_misalign
);

  // Decode the select field into a redirect request and its target
  always_comb begin
    o_redirect = 1'b0;
    o_target   = i_branch_target;
    case (i_pc_selection)
      PC_JALR: begin
        o_redirect = i_redirect_valid;
        o_target   = i_alu_result & ~32'h0000_0001;
      end
      PC_BRANCH: begin
        o_redirect = i_redirect_valid;
        o_target   = i_branch_target;
      end
      default: begin
        o_redirect = 1'b0;
        o_target   = i_branch_target;
      end
    endcase
  end

  assign o_misalign = o_redirect & is_misaligned(o_target);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer: holds the PC, issues instruction fetch requests and
// applies branch/jump redirects, trapping on misaligned targets.
module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_selection,
  input  logic        redirect_valid,
  input  logic [31:0] branch_target,
  input  logic [31:0] alu_result,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        misalign_trap,
  output logic [31:0] fetch_count
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_count;
  logic         r_imem_req;
  logic         r_flush;
  logic         r_misalign_trap;

  logic         w_redirect;
  logic         w_misalign;
  logic [31:0]  w_target;
  logic         w_fetch_done;

  next_pc_sel u_next_pc_sel (
    .i_pc_selection   (pc_selection),
    .i_redirect_valid (redirect_valid),
    .i_branch_target  (branch_target),
    .i_alu_result     (alu_result),
    .o_redirect       (w_redirect),
    .o_target         (w_target),
    .o_misalign       (w_misalign)
  );

  // A redirect in the same cycle wins, so that fetch is discarded, not counted
  assign w_fetch_done = (r_state == ST_RUN) & r_imem_req & imem_ack & ~stall & ~w_redirect;

  // Fetch FSM with PC and registered request/flush/trap outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_BOOT;
      r_pc            <= RESET_PC;
      r_imem_req      <= 1'b0;
      r_flush         <= 1'b0;
      r_misalign_trap <= 1'b0;
    end else begin
      r_flush         <= 1'b0;
      r_misalign_trap <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_RUN;
          r_imem_req <= 1'b1;
        end
        ST_RUN: begin
          if (w_redirect && w_misalign) begin
            r_state         <= ST_TRAP;
            r_pc            <= TRAP_VEC;
            r_imem_req      <= 1'b0;
            r_flush         <= 1'b1;
            r_misalign_trap <= 1'b1;
          end else if (w_redirect) begin
            r_pc    <= w_target;
            r_flush <= 1'b1;
          end else if (w_fetch_done) begin
            r_pc <= r_pc + 32'd4;
          end else begin
            r_pc <= r_pc;
          end
        end
        ST_TRAP: begin
          r_state    <= ST_RUN;
          r_imem_req <= 1'b1;
        end
        default: begin
          r_state    <= ST_BOOT;
          r_pc       <= RESET_PC;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Completed-fetch counter, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= 32'd0;
    end else begin
      r_fetch_count <= r_fetch_count + {31'd0, w_fetch_done};
    end
  end

  assign imem_req      = r_imem_req;
  assign imem_addr     = r_pc;
  assign pc_out        = r_pc;
  assign pc_plus4      = r_pc + 32'd4;
  assign flush         = r_flush;
  assign misalign_trap = r_misalign_trap;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a behavioural model predicts each
// cycle's outputs, queues them, and they are compared after the clock edge.
module tb_fetch_pc_unit;
  import fetch_pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_selection = 2'b00;
  logic        redirect_valid = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] alu_result = 32'd0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr, pc_out, pc_plus4, fetch_count;
  logic        flush, misalign_trap;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_selection(pc_selection),
    .redirect_valid(redirect_valid), .branch_target(branch_target),
    .alu_result(alu_result), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .flush(flush), .misalign_trap(misalign_trap),
    .fetch_count(fetch_count)
  );

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        flush;
    logic        trap;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  int          m_state;   // 0 boot, 1 run, 2 trap
  logic [31:0] m_pc, m_cnt;
  logic        m_req, m_flush, m_trap;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 32'h0000_0000; m_cnt = 32'd0;
    m_req = 1'b0; m_flush = 1'b0; m_trap = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pc"}, pc_out, 32'h0000_0000);
    check_val({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check_val({tag, "_flush"}, {31'd0, flush}, 32'd0);
    check_val({tag, "_trap"}, {31'd0, misalign_trap}, 32'd0);
    check_val({tag, "_cnt"}, fetch_count, 32'd0);
  endtask

  // Drive one cycle of inputs, predict, queue, then compare after the edge.
  task automatic cycle(input logic [1:0] sel, input logic rv, input logic [31:0] bt,
                       input logic [31:0] alu, input logic st, input logic ak);
    exp_t e;
    logic [31:0] tgt;
    logic redir;
    pc_selection = sel; redirect_valid = rv; branch_target = bt;
    alu_result = alu; stall = st; imem_ack = ak;
    m_flush = 1'b0; m_trap = 1'b0;
    if (m_state == 0) begin
      m_state = 1; m_req = 1'b1;
    end else if (m_state == 2) begin
      m_state = 1; m_req = 1'b1;
    end else begin
      redir = rv && (sel == 2'b01 || sel == 2'b10);
      tgt = (sel == 2'b01) ? {alu[31:1], 1'b0} : bt;
      if (redir && tgt[1:0] != 2'b00) begin
        m_pc = 32'h0000_0100; m_trap = 1'b1; m_flush = 1'b1; m_state = 2; m_req = 1'b0;
      end else if (redir) begin
        m_pc = tgt; m_flush = 1'b1;
      end else if (ak && !st) begin
        m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
      end
    end
    e.req = m_req; e.pc = m_pc; e.flush = m_flush; e.trap = m_trap; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("req", {31'd0, imem_req}, {31'd0, e.req});
    check_val("addr", imem_addr, e.pc);
    check_val("pc", pc_out, e.pc);
    check_val("plus4", pc_plus4, e.pc + 32'd4);
    check_val("flush", {31'd0, flush}, {31'd0, e.flush});
    check_val("trap", {31'd0, misalign_trap}, {31'd0, e.trap});
    check_val("count", fetch_count, e.cnt);
  endtask

  initial begin
    model_reset();
    #2;
    check_reset_outputs("rst");
    #6 rst_n = 1'b1;

    // Boot cycle (redirect must be ignored), then sequential fetches 0,4,8
    cycle(2'b10, 1'b1, 32'h0000_0800, 32'd0, 1'b0, 1'b1);
    check_val("boot_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_val("seq_addr", imem_addr, 32'h0000_000C);
    check_val("seq_cnt", fetch_count, 32'd3);

    // Branch to 0x40, then stall three cycles with ack held high
    cycle(2'b10, 1'b1, 32'h0000_0040, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    check_val("stall_pc", pc_out, 32'h0000_0040);
    check_val("stall_cnt", fetch_count, 32'd3);

    // Redirect beats stall; flush lasts one cycle
    cycle(2'b10, 1'b1, 32'h0000_0080, 32'd0, 1'b1, 1'b1);
    check_val("br_pc", pc_out, 32'h0000_0080);
    check_val("br_flush", {31'd0, flush}, 32'd1);
    cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // jalr with bit0 cleared, aligned
    cycle(2'b01, 1'b1, 32'h0000_0FF0, 32'h0000_0201, 1'b0, 1'b1);
    check_val("jalr_pc", pc_out, 32'h0000_0200);
    // jalr to 0x123 -> 0x122 misaligned: trap; redirect during trap ignored
    cycle(2'b01, 1'b1, 32'd0, 32'h0000_0123, 1'b0, 1'b1);
    check_val("mis_pc", pc_out, 32'h0000_0100);
    check_val("mis_req", {31'd0, imem_req}, 32'd0);
    cycle(2'b10, 1'b1, 32'h0000_0500, 32'd0, 1'b0, 1'b1);
    check_val("post_trap_addr", imem_addr, 32'h0000_0100);
    cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Non-redirecting selections, and select 10 without valid
    cycle(2'b00, 1'b1, 32'h0000_0600, 32'h0000_0600, 1'b0, 1'b1);
    cycle(2'b11, 1'b1, 32'h0000_0600, 32'h0000_0600, 1'b0, 1'b1);
    cycle(2'b10, 1'b0, 32'h0000_0600, 32'h0000_0600, 1'b0, 1'b1);
    cycle(2'b01, 1'b0, 32'h0000_0600, 32'h0000_0601, 1'b0, 1'b0);

    // Back-to-back redirects: later wins, flush stays high
    cycle(2'b10, 1'b1, 32'h0000_0300, 32'd0, 1'b0, 1'b1);
    cycle(2'b10, 1'b1, 32'h0000_0400, 32'd0, 1'b0, 1'b1);
    check_val("b2b_pc", pc_out, 32'h0000_0400);
    check_val("b2b_flush", {31'd0, flush}, 32'd1);

    // Misaligned branch target traps as well
    cycle(2'b10, 1'b1, 32'h0000_0202, 32'd0, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // PC and counter wrap at 2^32
    cycle(2'b10, 1'b1, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b1);
    force dut.r_fetch_count = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    release dut.r_fetch_count;
    cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_val("wrap_pc", pc_out, 32'h0000_0000);
    check_val("wrap_cnt", fetch_count, 32'h0000_0000);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            {22'd0, 8'($urandom), 2'($urandom_range(0, 3) == 0 ? 2 : 0)},
            {22'd0, 10'($urandom)}, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) != 0));
    end

    // Reset while a request is pending and unacknowledged
    cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    #1 rst_n = 1'b1;
    cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_val("rerun_cnt", fetch_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded at reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, the PC loaded on a misaligned control-transfer target.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pc_selection  input  2  branch-control select: 00 seq, 01 jalr (ALU), 10 branch/jal target, 11 seq.
REQ-006 SHALL have port redirect_valid  input  1  execute stage holds a valid instruction whose pc_selection is meaningful.
REQ-007 SHALL have port branch_target  input  32  PC-relative target from the branch adder.
REQ-008 SHALL have port alu_result  input  32  jalr target from the ALU.
REQ-009 SHALL have port stall  input  1  decode cannot accept a new instruction.
REQ-010 SHALL have port imem_req  output  1  fetch request valid.
REQ-011 SHALL have port imem_addr  output  32  fetch address; equals pc.
REQ-012 SHALL have port imem_ack  input  1  memory accepts/returns the request this cycle.
REQ-013 SHALL have port pc_out  output  32  current PC.
REQ-014 SHALL have port pc_plus4  output  32  pc_out + 4, combinational, for jal/jalr link.
REQ-015 SHALL have port flush  output  1  one-cycle pulse: discard younger in-flight instructions.
REQ-016 SHALL have port misalign_trap  output  1  one-cycle pulse on misaligned target.
REQ-017 SHALL have port fetch_count  output  32  number of completed fetches since reset.

Function
REQ-018 SHALL implement states BOOT, RUN, TRAP.
REQ-019 BOOT SHALL last exactly one cycle after rst_n deasserts, imem_req=0, then go RUN.
REQ-020 In RUN, imem_req SHALL be 1 and imem_addr SHALL equal pc_out.
REQ-021 A fetch completes when imem_req && imem_ack && !stall; pc SHALL then advance to pc+4 (mod 2^32, wraps) and fetch_count SHALL increment (wraps at 2^32).
REQ-022 With stall=1 or imem_ack=0 and no redirect, pc and fetch_count SHALL hold and imem_req SHALL stay 1 (request held stable).
REQ-023 Redirect = redirect_valid && pc_selection in {01,10}; target = alu_result with bit0 cleared for 01, branch_target for 10.
REQ-024 Selection 00 or 11, or redirect_valid=0, SHALL not redirect.
REQ-025 Redirect SHALL take priority over stall and ack: pc <= target next cycle, flush=1 for that one cycle, same-cycle fetch completion not counted.
REQ-026 If target[1:0] != 0, SHALL instead set pc <= TRAP_VEC, pulse misalign_trap and flush for one cycle, enter TRAP.
REQ-027 TRAP SHALL last one cycle with imem_req=0, then return to RUN fetching TRAP_VEC.
REQ-028 Redirects arriving in BOOT or TRAP SHALL be ignored.
REQ-029 Back-to-back redirects SHALL each take effect; the later one wins pc and flush stays asserted.

Reset
REQ-030 On rst_n=0, asynchronously: pc_out=RESET_PC, state=BOOT, imem_req=0, flush=0, misalign_trap=0, fetch_count=0.
REQ-031 Reset mid-request SHALL abandon the request; no completion counted.

Structure
REQ-032 pc_selection encodings, state encoding and RESET_PC/TRAP_VEC defaults SHALL live in the shared processor package.
REQ-033 Target select and misalignment check SHALL be one sub-module, next_pc_sel, combinational.

Verification
REQ-034 Reset release, imem_ack=1, stall=0 -> BOOT 1 cycle, then imem_addr 0,4,8; fetch_count 1,2,3.
REQ-035 pc=0x40, stall=1 for 3 cycles, ack=1 -> pc stays 0x40, count unchanged, imem_req=1 throughout.
REQ-036 pc=0x40, redirect_valid=1, sel=10, branch_target=0x80, stall=1 -> next pc 0x80, flush=1 one cycle.
REQ-037 sel=01, alu_result=0x0000_0123 -> target 0x122, misalign_trap=1, pc=0x100, imem_req=0 one cycle, then fetch 0x100.
REQ-038 pc=0xFFFF_FFFC, completed fetch -> pc=0x0000_0000; fetch_count=0xFFFF_FFFF plus one completion -> 0.
REQ-039 rst_n low while imem_req=1, ack=0 -> pc=RESET_PC immediately, fetch_count=0, imem_req=0.
